// File: rtl/fir_pkg.sv
// Shared defaults and helpers for the time-multiplexed FIR MAC datapath.
package fir_pkg;

    localparam int COEF_WIDTH_D = 16;
    localparam int DATA_WIDTH_D = 3;
    localparam int ACC_WIDTH_D  = 25;
    localparam int NUM_CH_D     = 4;
    localparam int NUM_TAPS_D   = 10;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

    // Accumulator limits at the default width.
    localparam logic signed [ACC_WIDTH_D-1:0] ACC_MAX_D = {1'b0, {(ACC_WIDTH_D-1){1'b1}}};
    localparam logic signed [ACC_WIDTH_D-1:0] ACC_MIN_D = {1'b1, {(ACC_WIDTH_D-1){1'b0}}};

endpackage

// File: rtl/fir_mac_sat_add.sv
// Signed accumulator adder: one extra bit of headroom detects overflow,
// which is then either clamped to the rails or left to wrap.
module fir_mac_sat_add
    import fir_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_D,
    parameter bit SAT_EN    = 1'b1
)(
    input  logic signed [ACC_WIDTH-1:0] a,
    input  logic signed [ACC_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        ovf
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] wide;

    assign wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    // Top two bits disagree exactly when the true sum left the ACC_WIDTH range.
    assign ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];

    // Clamp toward the sign of the true sum, or keep the low bits in wrap mode.
    always_comb begin
        sum = wide[ACC_WIDTH-1:0];
        if (ovf && SAT_EN) begin
            sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/fir_mac_multich.sv
// Multi-channel pipelined MAC: S1 multiplies and registers beat tags,
// S2 does the per-channel read-modify-write and emits finished sums.
//
// Input handshake: the engine is always ready. A beat is transferred on every
// rising edge where iValid=1; iFirst/iLast/iCh/iCoeff/iData are only looked at
// when iValid=1. There is no backpressure and oValid is a one-cycle strobe
// with no ready; the consumer must take it on the cycle it is high.
module fir_mac_multich
    import fir_pkg::*;
#(
    parameter int COEF_WIDTH = COEF_WIDTH_D,
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ACC_WIDTH  = ACC_WIDTH_D,
    parameter int NUM_CH     = NUM_CH_D,
    parameter int NUM_TAPS   = NUM_TAPS_D,
    parameter bit SAT_EN     = 1'b1,
    localparam int CH_W      = ch_width(NUM_CH)
)(
    input  logic                         iClk12M,
    input  logic                         iRst,
    input  logic                         iValid,
    input  logic                         iFirst,
    input  logic                         iLast,
    input  logic [CH_W-1:0]              iCh,
    input  logic [COEF_WIDTH-1:0]        iCoeff,
    input  logic [DATA_WIDTH-1:0]        iData,
    output logic                         oValid,
    output logic [CH_W-1:0]              oCh,
    output logic signed [ACC_WIDTH-1:0]  oMac,
    output logic                         oSat,
    output logic                         oErr
);

    localparam int PROD_W = COEF_WIDTH + DATA_WIDTH;
    localparam int CNT_W  = clog2(NUM_TAPS + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TAPS_L  = CNT_W'(NUM_TAPS);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

    if (ACC_WIDTH < PROD_W) begin : g_acc_width_check
        $error("fir_mac_multich: ACC_WIDTH must be >= COEF_WIDTH+DATA_WIDTH");
    end
    if (NUM_CH < 1) begin : g_num_ch_check
        $error("fir_mac_multich: NUM_CH must be >= 1");
    end

    // ---------------- S1: multiply and tag ----------------
    logic                      ch_illegal;
    logic                      beat_ok;
    logic signed [PROD_W-1:0]  prod;

    logic                      rV1;
    logic                      rF1;
    logic                      rL1;
    logic [CH_W-1:0]           rCh1;
    logic signed [PROD_W-1:0]  rMul;

    assign ch_illegal = ({1'b0, iCh} >= NUM_CH_L);
    assign beat_ok    = iValid & ~ch_illegal;
    // Both operands sign-extended to the full product width, so the low
    // PROD_W bits of the product are the exact signed result.
    assign prod = $signed({{DATA_WIDTH{iCoeff[COEF_WIDTH-1]}}, iCoeff})
                * $signed({{COEF_WIDTH{iData[DATA_WIDTH-1]}}, iData});

    // Register product and tags; dropped or idle beats carry a zero product.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            rV1  <= 1'b0;
            rF1  <= 1'b0;
            rL1  <= 1'b0;
            rCh1 <= '0;
            rMul <= '0;
        end else begin
            rV1  <= beat_ok;
            rF1  <= iFirst & beat_ok;
            rL1  <= iLast & beat_ok;
            rCh1 <= beat_ok ? iCh : '0;
            rMul <= beat_ok ? prod : '0;
        end
    end

    // ---------------- S2: per-channel accumulate ----------------
    logic signed [ACC_WIDTH-1:0] acc [NUM_CH];
    logic [CNT_W-1:0]            tapcnt [NUM_CH];
    logic [NUM_CH-1:0]           open_q;
    logic [NUM_CH-1:0]           sat_q;

    logic                        restart;
    logic signed [ACC_WIDTH-1:0] p;
    logic signed [ACC_WIDTH-1:0] add_a;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        ovf;
    logic                        sat_new;
    logic [CNT_W-1:0]            cnt_cur;
    logic [CNT_W-1:0]            cnt_new;

    // A beat on a closed channel restarts the sum just like a first tap;
    // adding to zero lets one adder serve both cases and never overflows.
    assign restart = rF1 | ~open_q[rCh1];
    assign p       = ACC_WIDTH'(rMul);
    assign add_a   = restart ? '0 : acc[rCh1];
    assign sat_new = restart ? ovf : (sat_q[rCh1] | ovf);
    assign cnt_cur = tapcnt[rCh1];
    assign cnt_new = restart ? CNT_ONE
                   : ((cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_ONE);

    fir_mac_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SAT_EN    (SAT_EN)
    ) u_sat_add (
        .a   (add_a),
        .b   (p),
        .sum (sum),
        .ovf (ovf)
    );

    // Update the addressed channel, emit finished sums and track protocol errors.
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]    <= '0;
                tapcnt[i] <= '0;
            end
            open_q <= '0;
            sat_q  <= '0;
            oValid <= 1'b0;
            oCh    <= '0;
            oMac   <= '0;
            oSat   <= 1'b0;
            oErr   <= 1'b0;
        end else begin
            oValid <= rV1 & rL1;
            if (iValid && ch_illegal) begin
                oErr <= 1'b1;
            end
            if (rV1) begin
                acc[rCh1]    <= sum;
                tapcnt[rCh1] <= cnt_new;
                sat_q[rCh1]  <= sat_new;
                open_q[rCh1] <= ~rL1;
                if (!rF1 && !open_q[rCh1]) begin
                    oErr <= 1'b1;
                end
                if (rL1) begin
                    oCh  <= rCh1;
                    oMac <= sum;
                    oSat <= sat_new;
                    if (cnt_new != TAPS_L) begin
                        oErr <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_multich.sv
// Directed bench for fir_mac_multich: default instance plus two 128-tap
// instances (saturating and wrapping) sharing one stimulus bus.
module tb_fir_mac_multich;

    logic        iClk12M = 1'b0;
    logic        iRst    = 1'b1;
    logic        iValid  = 1'b0;
    logic        iFirst  = 1'b0;
    logic        iLast   = 1'b0;
    logic [1:0]  iCh     = '0;
    logic [15:0] iCoeff  = '0;
    logic [2:0]  iData   = '0;

    logic        oValid,   oValid_s, oValid_w;
    logic [1:0]  oCh,      oCh_s,    oCh_w;
    logic [24:0] oMac,     oMac_s,   oMac_w;
    logic        oSat,     oSat_s,   oSat_w;
    logic        oErr,     oErr_s,   oErr_w;

    int n_vec = 0;
    int n_bad = 0;
    int strobes = 0;

    // ---------------- clock ----------------
    always #5 iClk12M = ~iClk12M;

    // Count result strobes of the default instance, sampled mid-cycle.
    always @(negedge iClk12M) begin
        if (oValid === 1'b1) strobes++;
    end

    fir_mac_multich dut (
        .iClk12M(iClk12M), .iRst(iRst), .iValid(iValid), .iFirst(iFirst),
        .iLast(iLast), .iCh(iCh), .iCoeff(iCoeff), .iData(iData),
        .oValid(oValid), .oCh(oCh), .oMac(oMac), .oSat(oSat), .oErr(oErr)
    );

    fir_mac_multich #(.NUM_TAPS(128), .SAT_EN(1'b1)) dut_sat (
        .iClk12M(iClk12M), .iRst(iRst), .iValid(iValid), .iFirst(iFirst),
        .iLast(iLast), .iCh(iCh), .iCoeff(iCoeff), .iData(iData),
        .oValid(oValid_s), .oCh(oCh_s), .oMac(oMac_s), .oSat(oSat_s), .oErr(oErr_s)
    );

    fir_mac_multich #(.NUM_TAPS(128), .SAT_EN(1'b0)) dut_wrap (
        .iClk12M(iClk12M), .iRst(iRst), .iValid(iValid), .iFirst(iFirst),
        .iLast(iLast), .iCh(iCh), .iCoeff(iCoeff), .iData(iData),
        .oValid(oValid_w), .oCh(oCh_w), .oMac(oMac_w), .oSat(oSat_w), .oErr(oErr_w)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic f, input logic l, input logic [1:0] c,
                              input logic [15:0] k, input logic [2:0] d);
        iValid = 1'b1; iFirst = f; iLast = l; iCh = c; iCoeff = k; iData = d;
        @(negedge iClk12M);
    endtask

    task automatic idle(input int n);
        iValid = 1'b0; iFirst = 1'b0; iLast = 1'b0; iCh = '0; iCoeff = '0; iData = '0;
        repeat (n) @(negedge iClk12M);
    endtask

    task automatic do_reset();
        idle(0);
        iRst = 1'b1;
        repeat (2) @(negedge iClk12M);
        iRst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", oValid); end
        n_vec++; if (oCh !== 2'd0) begin n_bad++; $display("FAIL reset_ch got %0d want 0", oCh); end
        n_vec++; if (oMac !== 25'd0) begin n_bad++; $display("FAIL reset_mac got %0d want 0", $signed(oMac)); end
        n_vec++; if (oSat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", oSat); end
        n_vec++; if (oErr !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", oErr); end
    endtask

    task automatic test_basic_sum();
        do_reset();
        for (int t = 0; t < 10; t++) drive_beat(t == 0, t == 9, 2'd0, 16'd100, 3'd1);
        n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %b want 0", oValid); end
        idle(1);
        n_vec++; if (oValid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", oValid); end
        n_vec++; if (oMac !== 25'd1000) begin n_bad++; $display("FAIL basic_mac got %0d want 1000", $signed(oMac)); end
        n_vec++; if (oCh !== 2'd0) begin n_bad++; $display("FAIL basic_ch got %0d want 0", oCh); end
        n_vec++; if (oSat !== 1'b0) begin n_bad++; $display("FAIL basic_sat got %b want 0", oSat); end
        n_vec++; if (oErr !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", oErr); end
        idle(1);
        n_vec++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL basic_strobe_len got %b want 0", oValid); end
        n_vec++; if (oMac !== 25'd1000) begin n_bad++; $display("FAIL basic_hold got %0d want 1000", $signed(oMac)); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int t = 0; t < 128; t++) drive_beat(t == 0, t == 127, 2'd0, 16'h8000, 3'b100);
        idle(1);
        n_vec++; if (oValid_s !== 1'b1) begin n_bad++; $display("FAIL sat_valid got %b want 1", oValid_s); end
        n_vec++; if (oMac_s !== 25'h0FFFFFF) begin n_bad++; $display("FAIL sat_mac got %0d want 16777215", $signed(oMac_s)); end
        n_vec++; if (oSat_s !== 1'b1) begin n_bad++; $display("FAIL sat_flag got %b want 1", oSat_s); end
        n_vec++; if (oErr_s !== 1'b0) begin n_bad++; $display("FAIL sat_err got %b want 0", oErr_s); end
        n_vec++; if (oMac_w !== 25'h1000000) begin n_bad++; $display("FAIL wrap_mac got %0d want -16777216", $signed(oMac_w)); end
        n_vec++; if (oSat_w !== 1'b1) begin n_bad++; $display("FAIL wrap_flag got %b want 1", oSat_w); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int t = 0; t < 10; t++) begin
            drive_beat(t == 0, t == 9, 2'd0, 16'd1, 3'd1);
            drive_beat(t == 0, t == 9, 2'd1, 16'd2, 3'b111);
        end
        n_vec++; if (oValid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid0 got %b want 1", oValid); end
        n_vec++; if (oCh !== 2'd0) begin n_bad++; $display("FAIL b2b_ch0 got %0d want 0", oCh); end
        n_vec++; if (oMac !== 25'd10) begin n_bad++; $display("FAIL b2b_mac0 got %0d want 10", $signed(oMac)); end
        idle(1);
        n_vec++; if (oValid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid1 got %b want 1", oValid); end
        n_vec++; if (oCh !== 2'd1) begin n_bad++; $display("FAIL b2b_ch1 got %0d want 1", oCh); end
        n_vec++; if (oMac !== 25'(-20)) begin n_bad++; $display("FAIL b2b_mac1 got %0d want -20", $signed(oMac)); end
        n_vec++; if (oErr !== 1'b0) begin n_bad++; $display("FAIL b2b_err got %b want 0", oErr); end
    endtask

    task automatic test_single_tap();
        int s0;
        do_reset();
        s0 = strobes;
        drive_beat(1'b1, 1'b1, 2'd3, 16'hFFF9, 3'd3);
        idle(1);
        n_vec++; if (oMac !== 25'(-21)) begin n_bad++; $display("FAIL single_mac got %0d want -21", $signed(oMac)); end
        n_vec++; if (oCh !== 2'd3) begin n_bad++; $display("FAIL single_ch got %0d want 3", oCh); end
        idle(3);
        n_vec++; if (strobes - s0 !== 1) begin n_bad++; $display("FAIL single_strobes got %0d want 1", strobes - s0); end
        n_vec++; if (oErr !== 1'b1) begin n_bad++; $display("FAIL single_err got %b want 1", oErr); end
    endtask

    task automatic test_reset_mid_sum();
        int s0;
        do_reset();
        s0 = strobes;
        for (int t = 0; t < 4; t++) drive_beat(t == 0, 1'b0, 2'd2, 16'd5, 3'd2);
        iRst = 1'b1;
        drive_beat(1'b0, 1'b1, 2'd2, 16'd5, 3'd2);
        iRst = 1'b0;
        idle(4);
        n_vec++; if (strobes - s0 !== 0) begin n_bad++; $display("FAIL midrst_strobes got %0d want 0", strobes - s0); end
        n_vec++; if (oMac !== 25'd0) begin n_bad++; $display("FAIL midrst_mac got %0d want 0", $signed(oMac)); end
        n_vec++; if (oErr !== 1'b0) begin n_bad++; $display("FAIL midrst_err got %b want 0", oErr); end
        for (int t = 0; t < 10; t++) drive_beat(t == 0, t == 9, 2'd2, 16'd5, 3'd2);
        idle(1);
        n_vec++; if (oValid !== 1'b1) begin n_bad++; $display("FAIL midrst_valid got %b want 1", oValid); end
        n_vec++; if (oMac !== 25'd100) begin n_bad++; $display("FAIL midrst_sum got %0d want 100", $signed(oMac)); end
        n_vec++; if (oCh !== 2'd2) begin n_bad++; $display("FAIL midrst_ch got %0d want 2", oCh); end
        n_vec++; if (oErr !== 1'b0) begin n_bad++; $display("FAIL midrst_err2 got %b want 0", oErr); end
    endtask

    task automatic test_missing_first();
        do_reset();
        drive_beat(1'b0, 1'b0, 2'd1, 16'd3, 3'd1);
        for (int t = 0; t < 9; t++) drive_beat(1'b0, t == 8, 2'd1, 16'hFFF6, 3'd2);
        idle(1);
        n_vec++; if (oValid !== 1'b1) begin n_bad++; $display("FAIL nofirst_valid got %b want 1", oValid); end
        n_vec++; if (oMac !== 25'(-177)) begin n_bad++; $display("FAIL nofirst_mac got %0d want -177", $signed(oMac)); end
        n_vec++; if (oErr !== 1'b1) begin n_bad++; $display("FAIL nofirst_err got %b want 1", oErr); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_sum();
        test_saturation();
        test_back_to_back();
        test_single_tap();
        test_reset_mid_sum();
        test_missing_first();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
